rf_alu_sequencer: RTL
=====================

Name: rf_alu_sequencer

Overview:
Multi-cycle controller that sequences the RF_ALU datapath (register file plus ALU) from a command stream.
- Accepts one command per valid/ready handshake: R-type ALU op, load-immediate, or compare.
- Drives the datapath's read/write address, write-data, RegWrite, FuncCode and ALUOp inputs, then captures ALUOut/Zero.
- Returns each result on a valid/ready response channel.
- Sits between a test/host command source and the RF_ALU instance; it is the only writer of RegWrite.

Parameters:
PROTECT_R0, 1, when 1 writes to register 0 are suppressed (RegWrite stays 0), but the response is still returned.

Ports:
clock  in  1  single clock; all state on rising edge
reset_n  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command (IDLE only)
cmd_op  in  2  0=R-type, 1=load-immediate, 2=compare, 3=reserved
cmd_rs  in  6  first source register
cmd_rt  in  6  second source register
cmd_rd  in  6  destination register
cmd_funct  in  6  R-type function code
cmd_imm  in  32  immediate for load-immediate
Read1  out  6  to RF read port 1
Read2  out  6  to RF read port 2
WriteReg  out  6  to RF write address
WriteData  out  32  to RF write data
RegWrite  out  1  to RF write enable
FuncCode  out  6  to ALU control
ALUOp  out  2  to ALU control
ALUOut  in  32  from ALU
Zero  in  1  from ALU
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_result  out  32  ALU result or immediate
rsp_zero  out  1  captured Zero flag
rsp_error  out  1  illegal op or funct; no write performed
busy  out  1  state != IDLE

Behaviour:
- All outputs are registered (Moore).
- Reset (async, reset_n=0): state=IDLE; every output is 0, including cmd_ready. cmd_ready rises on the first clock edge after reset_n deasserts.
- Reset mid-operation aborts the command: RegWrite drops immediately and no response is issued.
- States: IDLE, EXEC, WB, RSP.
- IDLE:
  - cmd_ready=1.
  - On an edge with cmd_valid&cmd_ready, latch the command and load Read1=rs, Read2=rt, WriteReg=rd, FuncCode=funct.
  - Decode the latched command:
    - op0 with funct in {32 add, 34 sub, 36 and, 37 or, 42 slt}: ALUOp=2, go to EXEC.
    - op2: ALUOp=1 (subtract), go to EXEC.
    - op1: result=imm, zero=(imm==0), go to WB.
    - op3, or op0 with any other funct: error=1, go to RSP with result=0, zero=0.
- EXEC (1 cycle):
  - Datapath addresses are stable.
  - At the edge ending EXEC, capture ALUOut into result and Zero into zero.
  - op0 goes to WB; op2 goes to RSP with no write.
- WB (1 cycle):
  - WriteData=result; RegWrite=1 for exactly this cycle, unless PROTECT_R0=1 and rd=0.
  - The RF commits at the edge ending WB.
  - RegWrite returns to 0 on entry to RSP.
- RSP:
  - rsp_valid=1; rsp_result, rsp_zero and rsp_error are held stable until the edge with rsp_ready=1.
  - On that edge go to IDLE.
- Latency, with acceptance at edge N:
  - R-type: RF write at edge N+2; rsp_valid from cycle N+3.
  - Load-immediate: write at edge N+1; rsp_valid from N+2.
  - Compare and error: rsp_valid from N+2 (error: N+1).
- rsp_valid is never combinationally dependent on rsp_ready.
- cmd_ready=0 in all non-IDLE states. A command is never accepted in the same cycle a response is consumed; the next acceptance is at the earliest edge N+1 after the IDLE return.
- ALUOp=0 and RegWrite=0 whenever no command is active.
- Back-to-back dependent commands (rd of cmd k = rs of cmd k+1) see the written value, because the write commits before the next EXEC.

Test Plan:
- Reset asserted mid-WB (async) -> RegWrite falls without a clock, all outputs 0, no response; after release cmd_ready=1 and the target register is unchanged.
- LI r5=0x55555555, LI r10=0xAAAAAAAB -> RegWrite high exactly one cycle each; rsp_result echoes each immediate, rsp_zero=0.
- R-type r12=r5 op r10:
  - add -> 0x00000000, Zero=1.
  - sub -> 0xAAAAAAAA.
  - and -> 0x00000001.
  - or -> 0xFFFFFFFF.
  - Each written to r12 and readable by a following compare.
- Compare r5,r5 -> rsp_zero=1, result 0, no RegWrite pulse. Compare r5,r10 -> rsp_zero=0.
- funct=33 or cmd_op=3 -> rsp_error=1, rsp_result=0, no RegWrite.
- LI r0=0x1234 with PROTECT_R0=1 -> no RegWrite, response returned.
- rsp_ready held low 5 cycles -> rsp_valid and response fields stable, cmd_ready=0, with cmd_valid held high throughout.
  - Release -> return to IDLE.
  - Next command accepted no earlier than the following edge.
  - Total R-type acceptance-to-response latency is exactly 3 cycles.

Source files
------------

// File: rtl/rf_alu_sequencer.sv
// Command sequencer for the register-file + ALU datapath: accepts R-type, load-immediate
// and compare commands, steps the datapath through EXEC/WB and returns each result.
module rf_alu_sequencer #(
   parameter bit PROTECT_R0 = 1'b1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [5:0]  cmd_rs,
   input  logic [5:0]  cmd_rt,
   input  logic [5:0]  cmd_rd,
   input  logic [5:0]  cmd_funct,
   input  logic [31:0] cmd_imm,
   output logic [5:0]  Read1,
   output logic [5:0]  Read2,
   output logic [5:0]  WriteReg,
   output logic [31:0] WriteData,
   output logic        RegWrite,
   output logic [5:0]  FuncCode,
   output logic [1:0]  ALUOp,
   input  logic [31:0] ALUOut,
   input  logic        Zero,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_result,
   output logic        rsp_zero,
   output logic        rsp_error,
   output logic        busy
);

   // state | meaning
   // IDLE  | waiting for a command, cmd_ready=1
   // EXEC  | datapath addresses stable, ALU result captured at exit
   // WB    | RegWrite pulse, register file commits at exit
   // RSP   | response held until rsp_ready
   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB, S_RSP} state_t;

   localparam logic [1:0] OP_RTYPE = 2'd0;
   localparam logic [1:0] OP_LI    = 2'd1;
   localparam logic [1:0] OP_CMP   = 2'd2;

   state_t      state, state_nxt;
   logic [1:0]  op_q, op_nxt;
   logic [5:0]  read1_nxt, read2_nxt, write_reg_nxt, func_code_nxt;
   logic [31:0] write_data_nxt, result_nxt;
   logic        reg_write_nxt, zero_nxt, error_nxt, rsp_valid_nxt;
   logic [1:0]  alu_op_nxt;
   logic        funct_legal;

   always_comb begin
      case (cmd_funct)
         6'd32, 6'd34, 6'd36, 6'd37, 6'd42: funct_legal = 1'b1;
         default:                           funct_legal = 1'b0;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         op_q       <= 2'd0;
         cmd_ready  <= 1'b0;
         Read1      <= '0;
         Read2      <= '0;
         WriteReg   <= '0;
         WriteData  <= '0;
         RegWrite   <= 1'b0;
         FuncCode   <= '0;
         ALUOp      <= '0;
         rsp_valid  <= 1'b0;
         rsp_result <= '0;
         rsp_zero   <= 1'b0;
         rsp_error  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_nxt;
         op_q       <= op_nxt;
         cmd_ready  <= (state_nxt == S_IDLE);
         Read1      <= read1_nxt;
         Read2      <= read2_nxt;
         WriteReg   <= write_reg_nxt;
         WriteData  <= write_data_nxt;
         RegWrite   <= reg_write_nxt;
         FuncCode   <= func_code_nxt;
         ALUOp      <= alu_op_nxt;
         rsp_valid  <= rsp_valid_nxt;
         rsp_result <= result_nxt;
         rsp_zero   <= zero_nxt;
         rsp_error  <= error_nxt;
         busy       <= (state_nxt != S_IDLE);
      end
   end

   always_comb begin
      state_nxt      = state;
      op_nxt         = op_q;
      read1_nxt      = Read1;
      read2_nxt      = Read2;
      write_reg_nxt  = WriteReg;
      write_data_nxt = WriteData;
      reg_write_nxt  = 1'b0;
      func_code_nxt  = FuncCode;
      alu_op_nxt     = ALUOp;
      rsp_valid_nxt  = rsp_valid;
      result_nxt     = rsp_result;
      zero_nxt       = rsp_zero;
      error_nxt      = rsp_error;

      case (state)
         S_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               op_nxt        = cmd_op;
               read1_nxt     = cmd_rs;
               read2_nxt     = cmd_rt;
               write_reg_nxt = cmd_rd;
               func_code_nxt = cmd_funct;
               error_nxt     = 1'b0;
               if (cmd_op == OP_RTYPE && funct_legal) begin
                  alu_op_nxt = 2'd2;
                  state_nxt  = S_EXEC;
               end else if (cmd_op == OP_CMP) begin
                  alu_op_nxt = 2'd1;
                  state_nxt  = S_EXEC;
               end else if (cmd_op == OP_LI) begin
                  alu_op_nxt     = 2'd0;
                  result_nxt     = cmd_imm;
                  zero_nxt       = (cmd_imm == 32'd0);
                  write_data_nxt = cmd_imm;
                  reg_write_nxt  = !(PROTECT_R0 && cmd_rd == 6'd0);
                  state_nxt      = S_WB;
               end else begin
                  alu_op_nxt    = 2'd0;
                  result_nxt    = 32'd0;
                  zero_nxt      = 1'b0;
                  error_nxt     = 1'b1;
                  rsp_valid_nxt = 1'b1;
                  state_nxt     = S_RSP;
               end
            end
         end
         S_EXEC: begin
            result_nxt = ALUOut;
            zero_nxt   = Zero;
            if (op_q == OP_RTYPE) begin
               write_data_nxt = ALUOut;
               reg_write_nxt  = !(PROTECT_R0 && WriteReg == 6'd0);
               state_nxt      = S_WB;
            end else begin
               rsp_valid_nxt = 1'b1;
               state_nxt     = S_RSP;
            end
         end
         S_WB: begin
            rsp_valid_nxt = 1'b1;
            state_nxt     = S_RSP;
         end
         S_RSP: begin
            // ALUOp is parked at 0 only once the command is fully retired
            if (rsp_ready) begin
               rsp_valid_nxt = 1'b0;
               alu_op_nxt    = 2'd0;
               state_nxt     = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

endmodule
